flash_boot_copier: RTL and testbench
====================================

Name: flash_boot_copier

Overview:
Parametrised flash-to-memory copy engine: on a start command it streams a run-time-selected range of bytes from the NOR flash reader and packs them into memory words. It writes those words to main memory through the debug memory-interface port. It adds run-time source/destination/length, byte-order selection, a word checksum and restartability. It sits between nor_flash_reader and the memory-interface arbiter and is used for boot loading and debug image transfers.

Parameters:
P_FADDR_N, 23, flash byte address width
P_MADDR_N, 25, memory word address width
P_WORD_BYTES, 4, bytes per memory word (power of two, 1..8); word width W = 8*P_WORD_BYTES
P_LEN_N, 22, word-count width

Ports:
iCLOCK  in  1  clock
inRESET  in  1  async active-low reset
iSTART  in  1  start pulse; accepted only in IDLE
iSRC_ADDR  in  P_FADDR_N  flash byte start address, sampled at start
iDST_ADDR  in  P_MADDR_N  memory word start address, sampled at start
iWORDS  in  P_LEN_N  number of words to copy, sampled at start
iLITTLE  in  1  0: first flash byte -> MSB; 1: first byte -> LSB; sampled at start
oBUSY  out  1  copy in progress
oDONE  out  1  one-cycle pulse at completion
oCHECKSUM  out  32  sum of written words, zero-extended or truncated to 32 bits, modulo 2^32
oDEBUG_VALID  out  1  equals oBUSY
oRQ_REQ  out  1  flash read request
iRQ_BUSY  in  1  reader request back-pressure
oRQ_ADDR  out  P_FADDR_N  flash byte address
oRD_REQ  out  1  pop a byte from the reader
iRD_EMPTY  in  1  reader output empty
iRD_DATA  in  8  reader output byte (show-ahead)
oMEMIF_REQ_VALID  out  1  memory write request
oMEMIF_REQ_DQM  out  P_WORD_BYTES  byte masks, always 0
oMEMIF_REQ_RW  out  1  always 1 (write)
oMEMIF_REQ_ADDR  out  P_MADDR_N  word address
oMEMIF_REQ_DATA  out  W  packed word
iMEMIF_REQ_LOCK  in  1  memory port busy

Behaviour:
- Reset: all outputs 0. State is IDLE. Counters, checksum and data registers are cleared. Reset mid-copy aborts the copy without a DONE pulse.
- States: IDLE, GATHER, WRITE, DONE.
- IDLE + iSTART: latch the inputs and clear the checksum and counters. If iWORDS == 0, go to DONE. Otherwise go to GATHER.
- Request side: runs independently of the state. oRQ_REQ = oBUSY && (req_cnt < iWORDS*P_WORD_BYTES). oRQ_ADDR = src + req_cnt, wrapping modulo 2^P_FADDR_N. req_cnt increments when oRQ_REQ && !iRQ_BUSY.
- GATHER: oRD_REQ = !iRD_EMPTY. iRD_DATA is captured into byte slot byte_idx in the same cycle. When byte_idx == P_WORD_BYTES-1 and a byte is popped, go to WRITE. byte_idx returns to 0.
- Byte placement: iLITTLE=0 puts slot k at bits [W-1-8k -: 8]; iLITTLE=1 puts it at [8k +: 8].
- WRITE: oMEMIF_REQ_VALID = !iMEMIF_REQ_LOCK; the write is accepted in that same cycle. oMEMIF_REQ_ADDR = dst + word_cnt, wrapping modulo 2^P_MADDR_N. On acceptance:
  - checksum += word;
  - word_cnt++;
  - if word_cnt+1 == iWORDS go to DONE, else go to GATHER.
- No reads are popped in WRITE. oRD_REQ is 0 outside GATHER.
- DONE: oDONE=1 for exactly one cycle, then IDLE. oBUSY is 1 in GATHER/WRITE and 0 in IDLE/DONE.
- oCHECKSUM holds its value until the next accepted start.
- iSTART outside IDLE is ignored, including in the DONE cycle.
- Latency: 1 cycle from the last byte pop to VALID. Best case is P_WORD_BYTES+1 cycles per word.

Decomposition:
- Shared package: state encodings (IDLE=2'h0, GATHER=2'h1, WRITE=2'h2, DONE=2'h3) and RW write constant 1'b1.
- One natural sub-module: flash_byte_packer (byte slot register file plus endian placement, parametrised by P_WORD_BYTES). The top holds the FSM, counters and checksum.

Test Plan:
- Reset values: assert inRESET=0 mid-run -> all outputs 0; no DONE; after release, IDLE with oBUSY=0.
- Basic BE copy: P_WORD_BYTES=4, src=0x10, dst=0x100, words=2, iLITTLE=0; flash bytes 11 22 33 44 55 66 77 88 -> writes 0x11223344@0x100, 0x55667788@0x101; checksum 0x6688AACC; one DONE pulse.
- Little-endian: same stimulus with iLITTLE=1 -> 0x44332211@0x100, 0x88776655@0x101.
- Zero length: words=0 -> DONE the cycle after start; no RQ_REQ or MEMIF valid.
- Back-pressure and wrap: iMEMIF_REQ_LOCK held for 5 cycles in WRITE -> VALID=0 and no pops; dst=2^25-1, words=2 -> second write at address 0. src=2^23-2 -> flash addresses wrap to 0.
- Start while busy and restart: pulse iSTART during GATHER -> ignored. A new start after DONE -> checksum cleared and fresh copy completes.

Source files
------------

// File: rtl/flash_boot_copier_pkg.sv
// Shared definitions for the flash-to-memory boot copy engine.
package flash_boot_copier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'h0,
        ST_GATHER = 2'h1,
        ST_WRITE  = 2'h2,
        ST_DONE   = 2'h3
    } state_t;

    localparam logic C_RW_WRITE = 1'b1;

endpackage

// File: rtl/flash_byte_packer.sv
// Byte slot register file that assembles flash bytes into one memory word,
// placing slot 0 at the MSB (big-endian) or LSB (little-endian).
module flash_byte_packer #(
    parameter int P_WORD_BYTES = 4,
    localparam int L_IDX_N = (P_WORD_BYTES > 1) ? $clog2(P_WORD_BYTES) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_wr,
    input  logic [L_IDX_N-1:0]        i_idx,
    input  logic [7:0]                i_data,
    input  logic                      i_little,
    output logic [8*P_WORD_BYTES-1:0] o_word
);

    logic [7:0] r_slot [P_WORD_BYTES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < P_WORD_BYTES; k++) r_slot[k] <= '0;
        end else if (i_wr) begin
            r_slot[i_idx] <= i_data;
        end
    end

    always_comb begin
        o_word = '0;
        for (int k = 0; k < P_WORD_BYTES; k++) begin
            if (i_little) o_word[8*k +: 8] = r_slot[k];
            else          o_word[8*(P_WORD_BYTES-1-k) +: 8] = r_slot[k];
        end
    end

endmodule

// File: rtl/flash_boot_copier.sv
// Copies a run-time selected flash byte range into memory words: the request
// side streams read addresses while the FSM gathers bytes and writes words.
module flash_boot_copier
    import flash_boot_copier_pkg::*;
#(
    parameter int P_FADDR_N    = 23,
    parameter int P_MADDR_N    = 25,
    parameter int P_WORD_BYTES = 4,
    parameter int P_LEN_N      = 22
) (
    input  logic                      iCLOCK,
    input  logic                      inRESET,
    input  logic                      iSTART,
    input  logic [P_FADDR_N-1:0]      iSRC_ADDR,
    input  logic [P_MADDR_N-1:0]      iDST_ADDR,
    input  logic [P_LEN_N-1:0]        iWORDS,
    input  logic                      iLITTLE,
    output logic                      oBUSY,
    output logic                      oDONE,
    output logic [31:0]               oCHECKSUM,
    output logic                      oDEBUG_VALID,
    output logic                      oRQ_REQ,
    input  logic                      iRQ_BUSY,
    output logic [P_FADDR_N-1:0]      oRQ_ADDR,
    output logic                      oRD_REQ,
    input  logic                      iRD_EMPTY,
    input  logic [7:0]                iRD_DATA,
    output logic                      oMEMIF_REQ_VALID,
    output logic [P_WORD_BYTES-1:0]   oMEMIF_REQ_DQM,
    output logic                      oMEMIF_REQ_RW,
    output logic [P_MADDR_N-1:0]      oMEMIF_REQ_ADDR,
    output logic [8*P_WORD_BYTES-1:0] oMEMIF_REQ_DATA,
    input  logic                      iMEMIF_REQ_LOCK
);

    localparam int L_W       = 8 * P_WORD_BYTES;
    localparam int L_SHIFT   = $clog2(P_WORD_BYTES);
    localparam int L_IDX_N   = (P_WORD_BYTES > 1) ? $clog2(P_WORD_BYTES) : 1;
    localparam int L_BYTES_N = P_LEN_N + L_SHIFT;
    localparam logic [L_IDX_N-1:0]   L_LAST_IDX = L_IDX_N'(P_WORD_BYTES - 1);
    localparam logic [L_IDX_N-1:0]   L_IDX_ONE  = L_IDX_N'(1);
    localparam logic [P_LEN_N-1:0]   L_LEN_ONE  = P_LEN_N'(1);
    localparam logic [L_BYTES_N-1:0] L_BYTE_ONE = L_BYTES_N'(1);

    state_t                 r_state;
    state_t                 w_state_nx;
    logic [P_FADDR_N-1:0]   r_src;
    logic [P_MADDR_N-1:0]   r_dst;
    logic [P_LEN_N-1:0]     r_words;
    logic [P_LEN_N-1:0]     r_word_cnt;
    logic [L_BYTES_N-1:0]   r_req_total;
    logic [L_BYTES_N-1:0]   r_req_cnt;
    logic [L_IDX_N-1:0]     r_byte_idx;
    logic                   r_little;
    logic [31:0]            r_checksum;

    logic                   w_busy;
    logic                   w_start;
    logic                   w_pop;
    logic                   w_rq_fire;
    logic                   w_wr_fire;
    logic                   w_last_byte;
    logic                   w_last_word;
    logic [L_W-1:0]         w_word;

    assign w_busy      = (r_state == ST_GATHER) || (r_state == ST_WRITE);
    assign w_start     = (r_state == ST_IDLE) && iSTART;
    assign w_pop       = (r_state == ST_GATHER) && !iRD_EMPTY;
    assign w_last_byte = (r_byte_idx == L_LAST_IDX);
    assign w_wr_fire   = (r_state == ST_WRITE) && !iMEMIF_REQ_LOCK;
    assign w_rq_fire   = oRQ_REQ && !iRQ_BUSY;
    assign w_last_word = ((r_word_cnt + L_LEN_ONE) == r_words);

    flash_byte_packer #(.P_WORD_BYTES(P_WORD_BYTES)) u_packer (
        .i_clk    (iCLOCK),
        .i_rst_n  (inRESET),
        .i_wr     (w_pop),
        .i_idx    (r_byte_idx),
        .i_data   (iRD_DATA),
        .i_little (r_little),
        .o_word   (w_word)
    );

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) r_state <= ST_IDLE;
        else          r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:   if (iSTART) w_state_nx = (iWORDS == '0) ? ST_DONE : ST_GATHER;
            ST_GATHER: if (w_pop && w_last_byte) w_state_nx = ST_WRITE;
            ST_WRITE:  if (w_wr_fire) w_state_nx = w_last_word ? ST_DONE : ST_GATHER;
            ST_DONE:   w_state_nx = ST_IDLE;
            default:   w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_src       <= '0;
            r_dst       <= '0;
            r_words     <= '0;
            r_little    <= 1'b0;
            r_req_total <= '0;
            r_req_cnt   <= '0;
            r_word_cnt  <= '0;
            r_byte_idx  <= '0;
            r_checksum  <= '0;
        end else if (w_start) begin
            r_src       <= iSRC_ADDR;
            r_dst       <= iDST_ADDR;
            r_words     <= iWORDS;
            r_little    <= iLITTLE;
            r_req_total <= L_BYTES_N'(iWORDS) << L_SHIFT;
            r_req_cnt   <= '0;
            r_word_cnt  <= '0;
            r_byte_idx  <= '0;
            r_checksum  <= '0;
        end else begin
            // Requests run ahead of the gather/write sequencing on purpose.
            if (w_rq_fire) r_req_cnt <= r_req_cnt + L_BYTE_ONE;
            if (w_pop)     r_byte_idx <= w_last_byte ? '0 : r_byte_idx + L_IDX_ONE;
            if (w_wr_fire) begin
                r_checksum <= r_checksum + 32'(w_word);
                r_word_cnt <= r_word_cnt + L_LEN_ONE;
            end
        end
    end

    assign oBUSY            = w_busy;
    assign oDEBUG_VALID     = w_busy;
    assign oDONE            = (r_state == ST_DONE);
    assign oCHECKSUM        = r_checksum;
    assign oRQ_REQ          = w_busy && (r_req_cnt < r_req_total);
    assign oRQ_ADDR         = r_src + P_FADDR_N'(r_req_cnt);
    assign oRD_REQ          = w_pop;
    assign oMEMIF_REQ_VALID = w_wr_fire;
    assign oMEMIF_REQ_DQM   = '0;
    assign oMEMIF_REQ_RW    = C_RW_WRITE;
    assign oMEMIF_REQ_ADDR  = r_dst + P_MADDR_N'(r_word_cnt);
    assign oMEMIF_REQ_DATA  = w_word;

endmodule

// File: tb/tb_flash_boot_copier.sv
// Bench for flash_boot_copier: flash reader and memory port models driven at
// the falling edge, with a word-level copy model for expected results.
module tb_flash_boot_copier;

    logic        iCLOCK;
    logic        inRESET;
    logic        iSTART;
    logic [22:0] iSRC_ADDR;
    logic [24:0] iDST_ADDR;
    logic [21:0] iWORDS;
    logic        iLITTLE;
    logic        oBUSY, oDONE, oDEBUG_VALID, oRQ_REQ, oRD_REQ;
    logic [31:0] oCHECKSUM;
    logic        iRQ_BUSY = 1'b0;
    logic [22:0] oRQ_ADDR;
    logic        iRD_EMPTY = 1'b1;
    logic [7:0]  iRD_DATA = 8'h00;
    logic        oMEMIF_REQ_VALID, oMEMIF_REQ_RW;
    logic [3:0]  oMEMIF_REQ_DQM;
    logic [24:0] oMEMIF_REQ_ADDR;
    logic [31:0] oMEMIF_REQ_DATA;
    logic        iMEMIF_REQ_LOCK = 1'b0;

    flash_boot_copier dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET), .iSTART(iSTART),
        .iSRC_ADDR(iSRC_ADDR), .iDST_ADDR(iDST_ADDR), .iWORDS(iWORDS), .iLITTLE(iLITTLE),
        .oBUSY(oBUSY), .oDONE(oDONE), .oCHECKSUM(oCHECKSUM), .oDEBUG_VALID(oDEBUG_VALID),
        .oRQ_REQ(oRQ_REQ), .iRQ_BUSY(iRQ_BUSY), .oRQ_ADDR(oRQ_ADDR),
        .oRD_REQ(oRD_REQ), .iRD_EMPTY(iRD_EMPTY), .iRD_DATA(iRD_DATA),
        .oMEMIF_REQ_VALID(oMEMIF_REQ_VALID), .oMEMIF_REQ_DQM(oMEMIF_REQ_DQM),
        .oMEMIF_REQ_RW(oMEMIF_REQ_RW), .oMEMIF_REQ_ADDR(oMEMIF_REQ_ADDR),
        .oMEMIF_REQ_DATA(oMEMIF_REQ_DATA), .iMEMIF_REQ_LOCK(iMEMIF_REQ_LOCK)
    );

    initial begin
        iCLOCK = 1'b0;
        forever #5 iCLOCK = ~iCLOCK;
    end

    typedef struct {
        logic [22:0] src;
        logic [24:0] dst;
        int          words;
        bit          little;
        int          busy_pct;
        int          lock_pct;
        bit          has_exp;
        logic [31:0] exp_cks;
        logic [31:0] exp_w0;
        bit          start_in_done;
        bit          mid_start;
    } vec_t;

    typedef struct { logic [24:0] a; logic [31:0] d; } wr_t;
    typedef struct { logic [7:0] b; int rdy; } pend_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          busy_pct = 0;
    int          lock_pct = 0;
    bit          lock_force = 0;
    int          pops, done_cnt, mon_err, last_rdy;
    logic [22:0] reqs[$];
    wr_t         writes[$];
    pend_t       pend[$];
    logic [7:0]  rdq[$];
    logic [7:0]  fmem [int unsigned];

    function automatic logic [7:0] fbyte(input logic [22:0] a);
        if (fmem.exists(a)) return fmem[a];
        return 8'((32'(a) * 32'd157) ^ (32'(a) >> 8)) ^ 8'h5A;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Flash reader and memory port models; handshakes sampled mid-cycle.
    always @(negedge iCLOCK) begin
        cyc++;
        if (!inRESET) begin
            pend.delete(); rdq.delete();
            iRD_EMPTY = 1'b1; iRD_DATA = 8'h00; iRQ_BUSY = 1'b0;
            iMEMIF_REQ_LOCK = lock_force;
        end else begin
            while (pend.size() > 0 && pend[0].rdy <= cyc) rdq.push_back(pend.pop_front().b);
            iRD_EMPTY = (rdq.size() == 0);
            iRD_DATA  = iRD_EMPTY ? 8'h00 : rdq[0];
            iRQ_BUSY  = ($urandom_range(0, 99) < busy_pct);
            iMEMIF_REQ_LOCK = lock_force || ($urandom_range(0, 99) < lock_pct);
            #1;
            if (oDEBUG_VALID !== oBUSY) mon_err++;
            if (oMEMIF_REQ_DQM !== 4'h0 || oMEMIF_REQ_RW !== 1'b1) mon_err++;
            if (oRD_REQ && iRD_EMPTY) mon_err++;
            if (oMEMIF_REQ_VALID && iMEMIF_REQ_LOCK) mon_err++;
            if (oDONE && oBUSY) mon_err++;
            if (oRQ_REQ && !oBUSY) mon_err++;
            if (oRQ_REQ && !iRQ_BUSY) begin
                pend_t p;
                reqs.push_back(oRQ_ADDR);
                p.b = fbyte(oRQ_ADDR);
                p.rdy = cyc + int'($urandom_range(1, 3));
                if (p.rdy < last_rdy) p.rdy = last_rdy;
                last_rdy = p.rdy;
                pend.push_back(p);
            end
            if (oRD_REQ) begin
                if (rdq.size() > 0) void'(rdq.pop_front());
                pops++;
            end
            if (oMEMIF_REQ_VALID) writes.push_back('{a: oMEMIF_REQ_ADDR, d: oMEMIF_REQ_DATA});
            if (oDONE) done_cnt++;
        end
    end

    task automatic next_cycle();
        @(negedge iCLOCK);
        #2;
    endtask

    task automatic start_copy(input vec_t v);
        next_cycle();
        reqs.delete(); writes.delete(); pend.delete(); rdq.delete();
        pops = 0; done_cnt = 0; mon_err = 0; last_rdy = 0;
        busy_pct = v.busy_pct; lock_pct = v.lock_pct;
        iSRC_ADDR = v.src; iDST_ADDR = v.dst; iWORDS = 22'(v.words); iLITTLE = v.little;
        iSTART = 1'b1;
        next_cycle();
        iSTART = 1'b0;
        // Scramble the inputs so only start-time values can produce a match.
        iSRC_ADDR = 23'($urandom); iDST_ADDR = 25'($urandom);
        iWORDS = 22'($urandom_range(1, 9)); iLITTLE = ~v.little;
    endtask

    task automatic wait_done(input bit start_in_done);
        int t = 0;
        while (done_cnt == 0 && t < 4000) begin
            next_cycle();
            t++;
        end
        check("done_seen", 64'(done_cnt != 0), 64'd1);
        if (start_in_done) begin
            iWORDS = 22'd3;
            iSTART = 1'b1;
            next_cycle();
            iSTART = 1'b0;
            check("start_in_done_ignored", 64'(oBUSY), 64'd0);
        end else begin
            next_cycle();
        end
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("idle_after_done", 64'({oBUSY, oDONE}), 64'd0);
    endtask

    task automatic verify(input vec_t v);
        logic [31:0] w;
        logic [31:0] cks = 32'h0;
        logic [7:0]  b;
        check($sformatf("nwrites_%0h", v.src), 64'(writes.size()), 64'(v.words));
        check($sformatf("nreqs_%0h", v.src), 64'(reqs.size()), 64'(v.words * 4));
        check($sformatf("npops_%0h", v.src), 64'(pops), 64'(v.words * 4));
        check($sformatf("protocol_%0h", v.src), 64'(mon_err), 64'd0);
        for (int i = 0; i < v.words * 4 && i < reqs.size(); i++)
            check($sformatf("rq_addr_%0d", i), 64'(reqs[i]), 64'(23'(v.src + 23'(i))));
        for (int i = 0; i < v.words; i++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++) begin
                b = fbyte(23'(v.src + 23'(i * 4 + k)));
                if (v.little) w[8*k +: 8] = b;
                else          w[31-8*k -: 8] = b;
            end
            cks += w;
            if (i < writes.size()) begin
                check($sformatf("wr_addr_%0d", i), 64'(writes[i].a), 64'(25'(v.dst + 25'(i))));
                check($sformatf("wr_data_%0d", i), 64'(writes[i].d), 64'(w));
            end
        end
        check($sformatf("checksum_%0h", v.src), 64'(oCHECKSUM), 64'(cks));
        if (v.has_exp) begin
            check("table_checksum", 64'(oCHECKSUM), 64'(v.exp_cks));
            if (writes.size() > 0) check("table_word0", 64'(writes[0].d), 64'(v.exp_w0));
        end
        if (v.dst == 25'h1FFFFFF && writes.size() > 1) check("dst_wrap", 64'(writes[1].a), 64'd0);
        if (v.src == 23'h7FFFFE && reqs.size() > 2) check("src_wrap", 64'(reqs[2]), 64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        start_copy(v);
        check("cks_cleared_at_start", 64'(oCHECKSUM), 64'd0);
        if (v.words > 0) check("busy_after_start", 64'(oBUSY), 64'd1);
        else             check("zero_len_done_next", 64'(oDONE), 64'd1);
        if (v.mid_start) begin
            repeat (3) next_cycle();
            iSRC_ADDR = 23'h7ABCDE; iWORDS = 22'd1; iSTART = 1'b1;
            next_cycle();
            iSTART = 1'b0;
            check("busy_after_mid_start", 64'(oBUSY), 64'd1);
        end
        wait_done(v.start_in_done);
        verify(v);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"}, 64'({oBUSY, oDONE, oDEBUG_VALID, oRQ_REQ, oRD_REQ, oMEMIF_REQ_VALID}), 64'd0);
        check({tag, "_checksum"}, 64'(oCHECKSUM), 64'd0);
        check({tag, "_rq_addr"}, 64'(oRQ_ADDR), 64'd0);
        check({tag, "_mem_addr"}, 64'(oMEMIF_REQ_ADDR), 64'd0);
        check({tag, "_mem_data"}, 64'(oMEMIF_REQ_DATA), 64'd0);
        check({tag, "_dqm"}, 64'(oMEMIF_REQ_DQM), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[5];
        vec_t v;
        logic [7:0] pat[8];

        pat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 8; i++) fmem[32'h10 + i] = pat[i];

        //          src          dst            w  le bsy lck has cks            w0           sid mid
        tbl[0] = '{23'h10,      25'h100,       2, 0, 0,  0,  1, 32'h6688AACC, 32'h11223344, 0, 0};
        tbl[1] = '{23'h10,      25'h100,       2, 1, 30, 30, 1, 32'hCCAA8866, 32'h44332211, 1, 0};
        tbl[2] = '{23'h7FFFFE,  25'h1FFFFFF,   2, 0, 20, 20, 0, 32'h0,        32'h0,        0, 0};
        tbl[3] = '{23'h1234,    25'h40,        5, 1, 40, 40, 0, 32'h0,        32'h0,        0, 1};
        tbl[4] = '{23'h300,     25'h7,         3, 0, 0,  0,  0, 32'h0,        32'h0,        1, 0};

        inRESET = 1'b0; iSTART = 1'b0; iSRC_ADDR = '0; iDST_ADDR = '0; iWORDS = '0; iLITTLE = 1'b0;
        #1;
        check_outputs_zero("reset0");
        check("reset0_rw", 64'(oMEMIF_REQ_RW), 64'd1);
        repeat (3) @(negedge iCLOCK);
        #3 inRESET = 1'b1;
        next_cycle();
        check("idle_after_reset0", 64'(oBUSY), 64'd0);

        for (int i = 0; i < 5; i++) run_vec(tbl[i]);

        // Zero-length copy: DONE straight after start, no traffic.
        v = '{23'h55, 25'h66, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0};
        run_vec(v);

        // Memory port locked for many cycles while a word is waiting.
        v = '{23'h500, 25'h20, 2, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0};
        lock_force = 1;
        start_copy(v);
        repeat (30) next_cycle();
        check("lock_no_writes", 64'(writes.size()), 64'd0);
        check("lock_pops_stop", 64'(pops), 64'd4);
        check("lock_valid_low", 64'(oMEMIF_REQ_VALID), 64'd0);
        check("lock_still_busy", 64'(oBUSY), 64'd1);
        lock_force = 0;
        wait_done(0);
        verify(v);

        for (int r = 0; r < 6; r++) begin
            v.src = (r % 2 == 0) ? 23'($urandom) : 23'(23'h7FFFF0 + $urandom_range(0, 15));
            v.dst = 25'($urandom);
            v.words = int'($urandom_range(1, 6));
            v.little = 1'($urandom);
            v.busy_pct = int'($urandom_range(0, 50));
            v.lock_pct = int'($urandom_range(0, 50));
            v.has_exp = 0; v.exp_cks = '0; v.exp_w0 = '0;
            v.start_in_done = 0; v.mid_start = 0;
            run_vec(v);
        end

        // Asynchronous reset in the middle of a copy.
        v = '{23'h900, 25'h300, 5, 0, 10, 10, 0, 32'h0, 32'h0, 0, 0};
        start_copy(v);
        repeat (8) next_cycle();
        check("busy_before_abort", 64'(oBUSY), 64'd1);
        @(negedge iCLOCK);
        #3 inRESET = 1'b0;
        #1;
        check_outputs_zero("abort");
        repeat (3) next_cycle();
        check("abort_no_done", 64'(done_cnt), 64'd0);
        @(negedge iCLOCK);
        #3 inRESET = 1'b1;
        next_cycle();
        check("abort_idle", 64'({oBUSY, oDONE}), 64'd0);
        check("abort_no_done_after", 64'(done_cnt), 64'd0);

        run_vec(tbl[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
